// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the set-associative cache controller.
// Holds the FSM state encoding, request-type constants and the lowest-set-bit helper.
package cache_ctrl_pkg;

    localparam int unsigned MAX_WAYS = 32;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteBack,
        StAllocate,
        StRefillDone,
        StWrAround
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned onehot_lowest_idx(input logic [MAX_WAYS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: the lowest-index invalid way wins, otherwise the round-robin pointer.
// Purely combinational; from_rr_o tells the controller whether to advance the pointer later.
module cache_victim_sel #(
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid_vec_i,
    input  logic [WAY_W-1:0]    rr_ptr_i,
    output logic [WAY_W-1:0]    victim_o,
    output logic                from_rr_o
);

    always_comb begin
        victim_o  = rr_ptr_i;
        from_rr_o = 1'b1;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_vec_i[i]) begin
                victim_o  = WAY_W'(i);
                from_rr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Controller FSM for an N-way set-associative cache with multi-beat lines.
// Handles hit/miss decode, victim write-back and refill bursts, and write-around misses.
module cache_ctrl_assoc
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned BEATS       = 4,
    parameter bit          WRITE_ALLOC = 1'b1,
    localparam int unsigned WAY_W  = $clog2(NUM_WAYS),
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_type,
    output logic                req_ready,
    input  logic [NUM_WAYS-1:0] hit_vec,
    input  logic [NUM_WAYS-1:0] valid_vec,
    input  logic [NUM_WAYS-1:0] dirty_vec,
    input  logic                mem_ready,
    output logic                read_en_mem,
    output logic                write_en_mem,
    output logic                read_en_cache,
    output logic                write_en_cache,
    output logic [WAY_W-1:0]    cache_way,
    output logic [BEAT_W-1:0]   beat_idx,
    output logic                refill,
    output logic                done_cache
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WAY_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                victim_rr_q, victim_rr_d;
    logic                req_type_q, req_type_d;

    logic [WAY_W-1:0]    sel_victim;
    logic                sel_from_rr;
    logic                hit;
    logic                last_beat;

    cache_victim_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_sel (
        .valid_vec_i (valid_vec),
        .rr_ptr_i    (rr_ptr_q),
        .victim_o    (sel_victim),
        .from_rr_o   (sel_from_rr)
    );

    assign hit       = |hit_vec;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        victim_d       = victim_q;
        victim_rr_d    = victim_rr_q;
        req_type_d     = req_type_q;

        req_ready      = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        cache_way      = victim_q;
        beat_idx       = beat_cnt_q;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_type_d = req_type;
                    state_d    = StCompare;
                end
            end

            StCompare: begin
                if (hit) begin
                    done_cache     = 1'b1;
                    cache_way      = WAY_W'(onehot_lowest_idx(MAX_WAYS'(hit_vec)));
                    write_en_cache = (req_type_q == REQ_WRITE);
                    read_en_cache  = (req_type_q == REQ_READ);
                    state_d        = StIdle;
                end else if ((req_type_q == REQ_WRITE) && !WRITE_ALLOC) begin
                    state_d = StWrAround;
                end else begin
                    victim_d    = sel_victim;
                    victim_rr_d = sel_from_rr;
                    beat_cnt_d  = '0;
                    // An invalid victim is never written back even if its dirty bit is stale.
                    state_d = (valid_vec[sel_victim] && dirty_vec[sel_victim]) ?
                              StWriteBack : StAllocate;
                end
            end

            StWriteBack: begin
                write_en_mem  = 1'b1;
                read_en_cache = 1'b1;
                if (mem_ready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = StAllocate;
                    end
                end
            end

            StAllocate: begin
                read_en_mem    = 1'b1;
                write_en_cache = mem_ready;
                if (mem_ready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = StRefillDone;
                    end
                end
            end

            StRefillDone: begin
                refill = 1'b1;
                if (victim_rr_q) begin
                    rr_ptr_d = rr_ptr_q + WAY_W'(1);
                end
                state_d = StCompare;
            end

            StWrAround: begin
                write_en_mem = 1'b1;
                beat_idx     = '0;
                if (mem_ready) begin
                    done_cache = 1'b1;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            req_type_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            victim_q    <= victim_d;
            victim_rr_q <= victim_rr_d;
            req_type_q  <= req_type_d;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Bench for cache_ctrl_assoc: directed and random requests checked against a
// transaction-level model of victim choice, burst beats, round-robin and latency.
module tb_cache_ctrl_assoc;

    localparam int NW = 4;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_valid_wa, req_type;
    logic [NW-1:0] hit_vec, valid_vec, dirty_vec;
    logic          mem_ready;

    logic          req_ready, read_en_mem, write_en_mem, read_en_cache, write_en_cache;
    logic [1:0]    cache_way, beat_idx;
    logic          refill, done_cache;

    logic          wa_req_ready, wa_read_en_mem, wa_write_en_mem, wa_read_en_cache;
    logic          wa_write_en_cache, wa_refill, wa_done_cache;
    logic [1:0]    wa_cache_way, wa_beat_idx;

    int checks = 0;
    int errors = 0;
    int rr_model = 0;

    always #5 clk = ~clk;

    cache_ctrl_assoc #(
        .NUM_WAYS    (NW),
        .BEATS       (NB),
        .WRITE_ALLOC (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_type       (req_type),
        .req_ready      (req_ready),
        .hit_vec        (hit_vec),
        .valid_vec      (valid_vec),
        .dirty_vec      (dirty_vec),
        .mem_ready      (mem_ready),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .cache_way      (cache_way),
        .beat_idx       (beat_idx),
        .refill         (refill),
        .done_cache     (done_cache)
    );

    cache_ctrl_assoc #(
        .NUM_WAYS    (NW),
        .BEATS       (NB),
        .WRITE_ALLOC (1'b0)
    ) dut_wa (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid_wa),
        .req_type       (req_type),
        .req_ready      (wa_req_ready),
        .hit_vec        (hit_vec),
        .valid_vec      (valid_vec),
        .dirty_vec      (dirty_vec),
        .mem_ready      (mem_ready),
        .read_en_mem    (wa_read_en_mem),
        .write_en_mem   (wa_write_en_mem),
        .read_en_cache  (wa_read_en_cache),
        .write_en_cache (wa_write_en_cache),
        .cache_way      (wa_cache_way),
        .beat_idx       (wa_beat_idx),
        .refill         (wa_refill),
        .done_cache     (wa_done_cache)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode: 0 = memory always ready, 1 = random ready, 2 = 3-cycle stall on refill beat 2.
    // rst_at_wb >= 0 asserts reset when that write-back beat is being presented.
    task automatic run_req(input logic typ, input logic [NW-1:0] hv, input logic [NW-1:0] vv,
                           input logic [NW-1:0] dv, input int mode, input int rst_at_wb,
                           input int exp_lat);
        int victim, exp_way, lat, wb, al, rf, stall_left;
        bit from_rr, miss, dirty, fin, aborted;

        miss   = (hv == '0);
        victim = -1;
        for (int i = NW - 1; i >= 0; i--) if (!vv[i]) victim = i;
        from_rr = (victim < 0);
        if (from_rr) victim = rr_model;
        dirty = vv[victim] && dv[victim];
        if (miss) begin
            exp_way = victim;
        end else begin
            exp_way = 0;
            for (int i = NW - 1; i >= 0; i--) if (hv[i]) exp_way = i;
        end

        @(negedge clk);
        req_valid = 1'b1; req_type = typ; hit_vec = hv; valid_vec = vv; dirty_vec = dv;
        mem_ready = 1'b0;
        #1;
        chk("req_ready_idle", 32'(req_ready), 1);
        lat = 1; wb = 0; al = 0; rf = 0; stall_left = 3; fin = 0; aborted = 0;

        for (int cyc = 0; cyc < 200 && !fin && !aborted; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mode == 0) begin
                mem_ready = 1'b1;
            end else if (mode == 2) begin
                if (al == 2 && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (write_en_mem && read_en_cache) begin
                chk("wb_way", 32'(cache_way), victim);
                chk("wb_beat", 32'(beat_idx), wb);
                if (rst_at_wb == wb) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_write_en_mem", 32'(write_en_mem), 0);
                    chk("rst_read_en_cache", 32'(read_en_cache), 0);
                    chk("rst_read_en_mem", 32'(read_en_mem), 0);
                    chk("rst_write_en_cache", 32'(write_en_cache), 0);
                    chk("rst_req_ready", 32'(req_ready), 1);
                    chk("rst_beat_idx", 32'(beat_idx), 0);
                    chk("rst_cache_way", 32'(cache_way), 0);
                    rr_model = 0;
                    aborted  = 1;
                end else if (mem_ready) begin
                    wb++;
                end
            end
            if (!aborted && read_en_mem) begin
                chk("al_way", 32'(cache_way), victim);
                chk("al_beat", 32'(beat_idx), al);
                chk("al_wen_cache", 32'(write_en_cache), 32'(mem_ready));
                chk("al_after_wb", wb, dirty ? NB : 0);
                if (mem_ready) al++;
            end
            if (!aborted && refill) begin
                rf++;
                chk("refill_beats", al, NB);
                hit_vec = NW'(1 << victim);
                if (from_rr) rr_model = (rr_model + 1) % NW;
            end
            if (!aborted && done_cache) begin
                fin = 1;
                chk("done_way", 32'(cache_way), exp_way);
                chk("done_wen", 32'(write_en_cache), 32'(typ));
                chk("done_ren", 32'(read_en_cache), 32'(!typ));
                chk("wb_count", wb, (miss && dirty) ? NB : 0);
                chk("refill_count", rf, miss ? 1 : 0);
                if (exp_lat > 0) chk("latency", lat, exp_lat);
            end
        end
        if (!fin && !aborted) chk("timeout", 0, 1);
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic run_wr_around();
        @(negedge clk);
        req_valid_wa = 1'b1; req_type = 1'b1; hit_vec = '0; valid_vec = '1; dirty_vec = '1;
        mem_ready = 1'b0;
        #1;
        chk("wa_ready", 32'(wa_req_ready), 1);
        @(negedge clk);
        req_valid_wa = 1'b0;
        #1;
        chk("wa_cmp_wmem", 32'(wa_write_en_mem), 0);
        chk("wa_cmp_done", 32'(wa_done_cache), 0);
        @(negedge clk);
        #1;
        chk("wa_stall_wmem", 32'(wa_write_en_mem), 1);
        chk("wa_stall_beat", 32'(wa_beat_idx), 0);
        chk("wa_stall_done", 32'(wa_done_cache), 0);
        chk("wa_stall_wen", 32'(wa_write_en_cache), 0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("wa_wmem", 32'(wa_write_en_mem), 1);
        chk("wa_done", 32'(wa_done_cache), 1);
        chk("wa_wen_cache", 32'(wa_write_en_cache), 0);
        chk("wa_refill", 32'(wa_refill), 0);
        chk("wa_rmem", 32'(wa_read_en_mem), 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("wa_back_idle", 32'(wa_req_ready), 1);
        chk("wa_idle_wmem", 32'(wa_write_en_mem), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid_wa = 1'b0; req_type = 1'b0;
        hit_vec = '0; valid_vec = '0; dirty_vec = '0; mem_ready = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_enables", 32'({read_en_mem, write_en_mem, read_en_cache, write_en_cache}), 0);
        chk("reset_pulses", 32'({refill, done_cache}), 0);
        chk("reset_way_beat", 32'({cache_way, beat_idx}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_req(1'b0, 4'b0100, 4'b1111, 4'b0000, 0, -1, 2);  // read hit, way 2
        run_req(1'b0, 4'b0000, 4'b0111, 4'b1111, 0, -1, 8);  // clean miss, invalid way 3
        run_req(1'b0, 4'b0000, 4'b1111, 4'b1111, 0, -1, 12); // dirty miss, rr way 0
        run_req(1'b0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 8);  // rr now points at way 1
        run_req(1'b0, 4'b0000, 4'b1011, 4'b0000, 2, -1, 11); // refill stall on beat 2
        run_req(1'b1, 4'b1010, 4'b1111, 4'b0000, 0, -1, 2);  // write hit, way 1
        run_req(1'b1, 4'b0000, 4'b1101, 4'b1111, 0, -1, 8);  // write-allocate miss
        run_wr_around();
        run_req(1'b0, 4'b0000, 4'b1111, 4'b1111, 0, 1, 0);   // reset mid write-back
        run_req(1'b0, 4'b0000, 4'b1111, 4'b0000, 0, -1, 8);  // rr restarts at way 0

        for (int n = 0; n < 30; n++) begin
            logic [NW-1:0] hv;
            hv = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            run_req(1'($urandom), hv, NW'($urandom), NW'($urandom), 1, -1, 0);
        end

        @(negedge clk);
        #1;
        chk("final_idle", 32'(req_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
- Parametrised cache controller FSM for an N-way set-associative, multi-beat-line cache.
- Sits between the CPU request port and the tag/data arrays and main-memory port.
- Adds the following: way selection, victim choice (invalid-first, then round-robin), beat-counted write-back and refill bursts, a request-ready handshake, and a selectable write-miss policy (allocate or write-around).

Parameters:
- NUM_WAYS, 4, number of ways; power of two, at least 2.
- BEATS, 4, memory beats per cache line; power of two, at least 1.
- WRITE_ALLOC, 1, 1 = write-allocate on write miss; 0 = write-around (no allocate).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU request valid
- req_type  in  1  0 = read, 1 = write
- req_ready  out  1  controller can accept a request
- hit_vec  in  NUM_WAYS  per-way tag match for the current set
- valid_vec  in  NUM_WAYS  per-way valid bits for the current set
- dirty_vec  in  NUM_WAYS  per-way dirty bits for the current set
- mem_ready  in  1  memory accepted or returned one beat this cycle
- read_en_mem  out  1  memory read (refill) request
- write_en_mem  out  1  memory write request
- read_en_cache  out  1  cache data read
- write_en_cache  out  1  cache data write
- cache_way  out  clog2(NUM_WAYS)  way index for the cache access
- beat_idx  out  clog2(BEATS), min 1  beat within the line
- refill  out  1  one-cycle pulse when a line has been filled
- done_cache  out  1  one-cycle pulse when the request completes

Behaviour:
- Reset: state IDLE, beat_cnt 0, rr_ptr 0, victim 0, req_type_q 0.
  - All outputs 0 except req_ready = 1.
  - Asserting rst mid-burst aborts the burst immediately; no further enables are driven.
- Outputs are Moore/Mealy combinational from state and inputs. Defaults: all 0, cache_way = victim, beat_idx = beat_cnt.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_type into req_type_q and go to COMPARE.
- COMPARE (hit = |hit_vec):
  - Hit: done_cache = 1; cache_way = lowest set bit of hit_vec; write_en_cache = req_type_q; read_en_cache = !req_type_q. Next state IDLE.
  - Write miss with WRITE_ALLOC = 0: go to WR_AROUND.
  - Any other miss: choose the victim as the lowest-index way with valid_vec = 0; if all ways are valid, the victim is rr_ptr. Latch the victim and clear beat_cnt.
    - If the victim is valid and dirty, go to WRITE_BACK; otherwise go to ALLOCATE.
  - No memory enables are driven in COMPARE.
- WRITE_BACK:
  - write_en_mem = 1 and read_en_cache = 1 on the victim at beat_cnt.
  - On mem_ready, beat_cnt increments.
  - On mem_ready with beat_cnt = BEATS-1: beat_cnt wraps to 0 and the next state is ALLOCATE.
  - Without mem_ready, state and beat are held (stall).
- ALLOCATE:
  - read_en_mem = 1; write_en_cache = mem_ready (victim, beat_cnt).
  - On mem_ready, beat_cnt increments.
  - On the last beat with mem_ready, go to REFILL_DONE.
- REFILL_DONE:
  - refill = 1 for exactly one cycle.
  - If the victim came from rr_ptr, rr_ptr increments modulo NUM_WAYS.
  - Next state COMPARE, which re-evaluates the request; a second miss repeats the sequence.
- WR_AROUND:
  - write_en_mem = 1; beat_idx = 0; no cache write.
  - On mem_ready: done_cache = 1 and next state IDLE.
- req_valid is ignored outside IDLE.
- Latency:
  - Hit: 2 cycles (IDLE, COMPARE).
  - Clean miss with zero-wait memory: 2 + BEATS + 1 + 1 cycles.
  - Dirty miss: adds BEATS cycles.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state_t enum: IDLE, COMPARE, WRITE_BACK, ALLOCATE, REFILL_DONE, WR_AROUND.
  - REQ_READ / REQ_WRITE constants.
  - A function onehot_lowest_idx.
- Sub-module cache_victim_sel: combinational invalid-first selection with a round-robin fallback; outputs the victim index and a from_rr flag.

Test Plan:
- Read hit: hit_vec = 4'b0100 → done_cache = 1, read_en_cache = 1, cache_way = 2 in COMPARE; back in IDLE next cycle with req_ready = 1.
- Clean miss: valid_vec = 4'b0111, mem_ready always 1 → victim 3; read_en_mem for 4 cycles; write_en_cache with beat_idx 0,1,2,3; refill pulse; COMPARE (with hit_vec = 4'b1000) → done_cache.
- Dirty miss: all valid, dirty_vec = 4'b1111, rr_ptr = 0 → 4 write-back beats on way 0, then 4 refill beats; rr_ptr = 1 afterwards.
- Memory stall: mem_ready low for 3 cycles on beat 2 of ALLOCATE → beat_idx holds 2 and write_en_cache stays 0 while stalled; burst completes after the stall.
- WRITE_ALLOC = 0, write miss → single write_en_mem; done_cache on mem_ready; no write_en_cache and no refill.
- rst asserted on beat 1 of WRITE_BACK → same cycle: all enables 0, req_ready = 1; beat_cnt and rr_ptr read 0 afterwards.
